// File: rtl/parity_pkg.sv
// Shared helpers for the parity checker family: the parity error function
// and the saturating counter increment.
package parity_pkg;

  // Widest data word / counter the helpers accept; callers size-cast into these.
  localparam int MAX_DATA_W = 256;
  localparam int MAX_CNT_W  = 64;

  // Error when data XOR parity does not match the selected parity sense.
  // Zero-extending the data does not change its XOR reduction.
  function automatic logic parity_err(input logic [MAX_DATA_W-1:0] data,
                                      input logic                  parity,
                                      input logic                  odd);
    return (^data) ^ parity ^ odd;
  endfunction

  // Increment a w-bit counter (held in a wider vector), holding at 2^w-1.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] cnt,
                                                   input int                   w);
    logic [MAX_CNT_W-1:0] max_val;
    max_val = (w >= MAX_CNT_W) ? '1 : ((MAX_CNT_W'(1) << w) - MAX_CNT_W'(1));
    return (cnt == max_val) ? cnt : cnt + MAX_CNT_W'(1);
  endfunction

endpackage

// File: rtl/parity_stream_checker_stats.sv
// Status block: sticky error flag plus saturating word/error counters.
// A clear in the same cycle as a counted word clears first, then counts.
module parity_stream_checker_stats
  import parity_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic             i_err,
  output logic             o_sticky,
  output logic [CNT_W-1:0] o_word_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  logic             r_sticky;
  logic [CNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_sticky_base;
  logic [CNT_W-1:0] w_word_base;
  logic [CNT_W-1:0] w_err_base;
  logic             w_sticky_nxt;
  logic [CNT_W-1:0] w_word_nxt;
  logic [CNT_W-1:0] w_err_nxt;

  assign w_sticky_base = i_clr ? 1'b0 : r_sticky;
  assign w_word_base   = i_clr ? '0   : r_word_cnt;
  assign w_err_base    = i_clr ? '0   : r_err_cnt;

  // Both counters saturate at the same value, so err_count never passes word_count.
  assign w_word_nxt   = i_inc ? CNT_W'(sat_inc(MAX_CNT_W'(w_word_base), CNT_W)) : w_word_base;
  assign w_err_nxt    = (i_inc && i_err) ? CNT_W'(sat_inc(MAX_CNT_W'(w_err_base), CNT_W))
                                         : w_err_base;
  assign w_sticky_nxt = w_sticky_base | (i_inc & i_err);

  // Status registers; reset wins over clear and over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky   <= 1'b0;
      r_word_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_sticky   <= w_sticky_nxt;
      r_word_cnt <= w_word_nxt;
      r_err_cnt  <= w_err_nxt;
    end
  end

  assign o_sticky   = r_sticky;
  assign o_word_cnt = r_word_cnt;
  assign o_err_cnt  = r_err_cnt;

endmodule

// File: rtl/parity_stream_checker.sv
// Streaming parity checker: valid/ready input, one registered output stage
// carrying the word and its parity error, plus sticky/counter status.
module parity_stream_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,   // 1..MAX_DATA_W
  parameter int ODD    = 0,   // 0 = even parity, 1 = odd parity
  parameter int CNT_W  = 16   // 1..MAX_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_parity,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  err_count,
  input  logic              clr_stats
);

  logic                  r_out_valid;
  logic [DATA_W-1:0]     r_out_data;
  logic                  r_out_err;

  logic                  w_accept;
  logic                  w_err;
  logic [MAX_DATA_W-1:0] w_data_ext;

  // Ready depends only on the output stage, never on in_valid.
  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_data_ext = MAX_DATA_W'(in_data);
  assign w_err      = parity_err(w_data_ext, in_parity, 1'(ODD));

  // Output stage: load on accept, drop valid on a drain with nothing new.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data;
      r_out_err   <= w_err;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;

  parity_stream_checker_stats #(.CNT_W(CNT_W)) u_stats (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (clr_stats),
    .i_inc      (w_accept),
    .i_err      (w_err),
    .o_sticky   (err_sticky),
    .o_word_cnt (word_count),
    .o_err_cnt  (err_count)
  );

endmodule
